// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider that borrows the shared execute-stage adder via add_* ports.
// Optional early-out compare state is enabled with `define DIV_SHORTCUT_EN.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             valid_out,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic [1:0]       add_ctrl,
    input  logic [WIDTH-1:0] add_result,
    input  logic [1:0]       add_flag
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef DIV_SHORTCUT_EN
    localparam logic [1:0] ST_CHECK = 2'd3;
    localparam logic [1:0] OP_CMP   = 2'b10;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] shift_s;
    logic             msb_s;
    logic             ge_s;
    logic [WIDTH-1:0] r_iter_s;
    logic [WIDTH-1:0] q_iter_s;

    // Partial-remainder step: a bit shifted out of R means S already exceeds any divisor.
    always_comb begin
        shift_s  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        msb_s    = r_q[WIDTH-1];
        ge_s     = msb_s | add_flag[0] | add_flag[1];
        q_iter_s = {q_q[WIDTH-2:0], ge_s};
        if (ge_s) begin
            r_iter_s = add_result;
        end else begin
            r_iter_s = shift_s;
        end
    end

    // Shared adder request, idle-encoded outside the arithmetic states.
    always_comb begin
        add_a    = {WIDTH{1'b0}};
        add_b    = {WIDTH{1'b0}};
        add_ctrl = OP_ADD;
        case (state_q)
            ST_ITER: begin
                add_a    = shift_s;
                add_b    = dvs_q;
                add_ctrl = OP_SUB;
            end
`ifdef DIV_SHORTCUT_EN
            ST_CHECK: begin
                add_a    = q_q;
                add_b    = dvs_q;
                add_ctrl = OP_CMP;
            end
`endif
            default: begin
                add_a    = {WIDTH{1'b0}};
                add_b    = {WIDTH{1'b0}};
                add_ctrl = OP_ADD;
            end
        endcase
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d   = dividend;
                    dvs_d = divisor;
                    r_d   = {WIDTH{1'b0}};
                    cnt_d = CNT_INIT;
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                        quot_d  = {WIDTH{1'b1}};
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
`ifdef DIV_SHORTCUT_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_ITER;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef DIV_SHORTCUT_EN
            ST_CHECK: begin
                if (add_flag == 2'b00) begin
                    state_d = ST_DONE;
                    quot_d  = {WIDTH{1'b0}};
                    rem_d   = q_q;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_ITER;
                end
            end
`endif
            ST_ITER: begin
                r_d = r_iter_s;
                q_d = q_iter_s;
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_DONE;
                    quot_d  = q_iter_s;
                    rem_d   = r_iter_s;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= {WIDTH{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready       = ready_q;
    assign valid_out   = valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
